// File: rtl/reflet_timer.sv
// reflet_timer: memory-mapped down-counting timer for the Reflet system bus.
//
// Counts prescaled clock ticks and raises a level interrupt when COUNT
// reaches zero on a tick.  Five word-stride registers live at base_addr:
//   k=0 CTRL     bit0 run, bit1 auto_reload, bit2 irq_en
//   k=1 PRESCALE full width
//   k=2 RELOAD   full width
//   k=3 COUNT    full width
//   k=4 STATUS   bit0 expired, bit1 missed (write-1-to-clear)
//
// Bus protocol: there is no handshake.  Every cycle is a transfer, and the
// block is either selected or not.  A write completes at the edge where
// write_en is high and the block is selected.  Read data is registered: the
// value selected at edge N is on data_out during cycle N+1.  data_out is
// zero otherwise, so it can be OR-merged onto the CPU read bus.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   enable    in   low freezes prescaler, COUNT and STATUS; writes still apply
//   addr      in   CPU byte address
//   data_in   in   write data
//   write_en  in   write strobe
//   data_out  out  registered read data, zero when not selected
//   irq       out  registered level interrupt (expired & irq_en)
module reflet_timer #(
  parameter int unsigned             wordsize  = 16,
  parameter logic [wordsize-1:0]     base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  localparam int unsigned          STRIDE     = wordsize / 8;
  localparam int unsigned          SHIFT      = $clog2(STRIDE);
  localparam logic [wordsize-1:0]  ALIGN_MASK = wordsize'(STRIDE - 1);
  localparam logic [wordsize-1:0]  ONE        = wordsize'(1);

  logic [2:0]          ctrl_q,     ctrl_d;
  logic [wordsize-1:0] prescale_q, prescale_d;
  logic [wordsize-1:0] reload_q,   reload_d;
  logic [wordsize-1:0] count_q,    count_d;
  logic [wordsize-1:0] pcnt_q,     pcnt_d;
  logic                expired_q,  expired_d;
  logic                missed_q,   missed_d;
  logic [wordsize-1:0] data_out_q, data_out_d;
  logic                irq_q,      irq_d;

  logic [wordsize-1:0] offset;
  logic [wordsize-1:0] k_full;
  logic [2:0]          k;
  logic                sel;
  logic                wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
  logic                active, pcnt_wrap, tick, expire;
  logic [wordsize-1:0] rdata;

  always_comb begin
    // Address decode: offset wraps modulo 2^wordsize, so addresses below
    // base_addr become huge indices and fall out of the window.
    offset = addr - base_addr;
    k_full = offset >> SHIFT;
    k      = k_full[2:0];
    sel    = ((offset & ALIGN_MASK) == '0) && (k_full <= wordsize'(4));

    wr_ctrl     = sel && write_en && (k == 3'd0);
    wr_prescale = sel && write_en && (k == 3'd1);
    wr_reload   = sel && write_en && (k == 3'd2);
    wr_count    = sel && write_en && (k == 3'd3);
    wr_status   = sel && write_en && (k == 3'd4);

    active    = ctrl_q[0] && enable;
    pcnt_wrap = active && (pcnt_q == prescale_q);
    // A tick is dropped when software stops the timer or overwrites COUNT
    // on the same edge; the written values take priority.
    tick      = pcnt_wrap && !(wr_ctrl && !data_in[0]) && !wr_count;
    expire    = tick && (count_q == '0);

    pcnt_d = pcnt_q;
    if (wr_ctrl && data_in[0]) begin
      pcnt_d = '0;
    end else if (active) begin
      pcnt_d = pcnt_wrap ? '0 : pcnt_q + ONE;
    end

    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d = data_in[2:0];
    end else if (expire && !ctrl_q[1]) begin
      ctrl_d[0] = 1'b0;
    end

    prescale_d = wr_prescale ? data_in : prescale_q;
    reload_d   = wr_reload   ? data_in : reload_q;

    count_d = count_q;
    if (wr_count) begin
      count_d = data_in;
    end else if (tick) begin
      if (count_q != '0)  count_d = count_q - ONE;
      else if (ctrl_q[1]) count_d = reload_q;
      else                count_d = '0;
    end

    // Expiry beats a simultaneous clear of expired; a clear of missed
    // always wins, even when this expiry would set it.
    expired_d = (expired_q && !(wr_status && data_in[0])) || expire;
    missed_d  = (missed_q || (expire && expired_q)) && !(wr_status && data_in[1]);

    case (k)
      3'd0:    rdata = {{(wordsize-3){1'b0}}, ctrl_q};
      3'd1:    rdata = prescale_q;
      3'd2:    rdata = reload_q;
      3'd3:    rdata = count_q;
      3'd4:    rdata = {{(wordsize-2){1'b0}}, missed_q, expired_q};
      default: rdata = '0;
    endcase
    data_out_d = (sel && !write_en) ? rdata : '0;

    // Built from next-state values so irq tracks expired/irq_en with no lag.
    irq_d = expired_d && ctrl_d[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      pcnt_q     <= '0;
      expired_q  <= 1'b0;
      missed_q   <= 1'b0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
      expired_q  <= expired_d;
      missed_q   <= missed_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule
